// File: rtl/irq_ack_decoder_if.sv
// Signal bundle between the CPU interrupt path and irq_ack_decoder.
// master = CPU / request side (drives requests, ack and EOI indices);
// slave  = irq_ack_decoder (drives pending/in-service state and pulses).
interface irq_ack_decoder_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] irq_in;
  logic         ack_valid;
  logic [W-1:0] ack_index;
  logic         eoi_valid;
  logic [W-1:0] eoi_index;
  logic [N-1:0] pending;
  logic [N-1:0] in_service;
  logic         irq_req;
  logic [N-1:0] irq_ack_out;
  logic [N-1:0] eoi_out;
  logic         ack_err;
  logic         eoi_err;

  modport master (
    output irq_in, ack_valid, ack_index, eoi_valid, eoi_index,
    input  pending, in_service, irq_req, irq_ack_out, eoi_out, ack_err, eoi_err
  );

  modport slave (
    input  irq_in, ack_valid, ack_index, eoi_valid, eoi_index,
    output pending, in_service, irq_req, irq_ack_out, eoi_out, ack_err, eoi_err
  );
endinterface

// File: rtl/irq_ack_decoder.sv
// Interrupt pending / in-service tracker.
// Rising edges on irq_in set pending bits. The CPU's ack and EOI indices are
// decoded back into one-hot masks that move bits from pending to in-service
// and retire them, with one-cycle one-hot pulses back to the peripherals.
//
// Handshake: ack_valid and eoi_valid are single-cycle qualifiers with no
// ready/back-pressure; every cycle a valid is high is one command, acted on
// at that rising edge against the state held before the edge. A command that
// hits no tracked bit produces a one-cycle error pulse instead of a change.
//
// N must be 2**W, so every index is in range and needs no bounds handling.
module irq_ack_decoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input logic            clk,
  input logic            reset,
  irq_ack_decoder_if.slave bus
);

  logic [N-1:0] irq_prev;
  logic [N-1:0] pending_q;
  logic [N-1:0] in_service_q;
  logic [N-1:0] irq_ack_q;
  logic [N-1:0] eoi_q;
  logic         ack_err_q;
  logic         eoi_err_q;

  logic [N-1:0] rise;
  logic [N-1:0] ack_dec;
  logic [N-1:0] eoi_dec;
  logic [N-1:0] ack_hit;
  logic [N-1:0] eoi_hit;
  logic [N-1:0] pending_next;
  logic [N-1:0] in_service_next;
  logic         ack_miss;
  logic         eoi_miss;

  // Edge detect, index decoders, hit masks and next-state vectors.
  always_comb begin
    rise    = bus.irq_in & ~irq_prev;
    ack_dec = '0;
    eoi_dec = '0;
    if (bus.ack_valid) ack_dec[bus.ack_index] = 1'b1;
    if (bus.eoi_valid) eoi_dec[bus.eoi_index] = 1'b1;
    ack_hit  = ack_dec & pending_q;
    eoi_hit  = eoi_dec & in_service_q;
    ack_miss = bus.ack_valid & ~(|ack_hit);
    eoi_miss = bus.eoi_valid & ~(|eoi_hit);
    // A fresh edge in the ack cycle re-arms the line; an EOI and an ack of
    // the same line in one cycle leave it in service.
    pending_next    = (pending_q & ~ack_hit) | rise;
    in_service_next = (in_service_q & ~eoi_hit) | ack_hit;
  end

  // State and one-cycle pulse registers; reset clears everything, no pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_ack_q    <= '0;
      eoi_q        <= '0;
      ack_err_q    <= 1'b0;
      eoi_err_q    <= 1'b0;
    end else begin
      irq_prev     <= bus.irq_in;
      pending_q    <= pending_next;
      in_service_q <= in_service_next;
      irq_ack_q    <= ack_hit;
      eoi_q        <= eoi_hit;
      ack_err_q    <= ack_miss;
      eoi_err_q    <= eoi_miss;
    end
  end

  assign bus.pending     = pending_q;
  assign bus.in_service  = in_service_q;
  assign bus.irq_req     = |pending_q;
  assign bus.irq_ack_out = irq_ack_q;
  assign bus.eoi_out     = eoi_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.eoi_err     = eoi_err_q;

endmodule

// File: tb/tb_irq_ack_decoder.sv
// Directed bench for irq_ack_decoder (N=8, W=3).
module tb_irq_ack_decoder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  irq_ack_decoder_if #(.N(8), .W(3)) bus ();

  irq_ack_decoder #(.N(8), .W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: inputs are set before calling, sampled at the next rising edge,
  // and outputs are read 1 time unit after that edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] irq, input logic av, input logic [2:0] ai,
                       input logic ev, input logic [2:0] ei);
    bus.irq_in    = irq;
    bus.ack_valid = av;
    bus.ack_index = ai;
    bus.eoi_valid = ev;
    bus.eoi_index = ei;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    cyc();
    total++;
    if ({bus.pending, bus.in_service, bus.irq_ack_out, bus.eoi_out} !== 32'h0) begin
      bad++; $display("FAIL reset_vectors got=%h exp=%h",
        {bus.pending, bus.in_service, bus.irq_ack_out, bus.eoi_out}, 32'h0);
    end
    total++;
    if ({bus.irq_req, bus.ack_err, bus.eoi_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {bus.irq_req, bus.ack_err, bus.eoi_err});
    end
    reset = 1'b0;
    cyc();
    total++;
    if (bus.pending !== 8'h00) begin
      bad++; $display("FAIL reset_idle_pending got=%h exp=00", bus.pending);
    end
  endtask

  task automatic test_basic_ack();
    drive(8'h20, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.pending !== 8'h20) begin
      bad++; $display("FAIL ack_pending_set got=%h exp=20", bus.pending);
    end
    total++;
    if (bus.irq_req !== 1'b1) begin
      bad++; $display("FAIL ack_irq_req got=%b exp=1", bus.irq_req);
    end
    drive(8'h20, 1'b1, 3'd5, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.irq_ack_out !== 8'h20) begin
      bad++; $display("FAIL ack_pulse got=%h exp=20", bus.irq_ack_out);
    end
    total++;
    if (bus.pending !== 8'h00 || bus.in_service !== 8'h20) begin
      bad++; $display("FAIL ack_state got=%h/%h exp=00/20", bus.pending, bus.in_service);
    end
    total++;
    if (bus.irq_req !== 1'b0 || bus.ack_err !== 1'b0) begin
      bad++; $display("FAIL ack_flags got=%b%b exp=00", bus.irq_req, bus.ack_err);
    end
    drive(8'h20, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.irq_ack_out !== 8'h00 || bus.pending !== 8'h00) begin
      bad++; $display("FAIL ack_pulse_end got=%h/%h exp=00/00", bus.irq_ack_out, bus.pending);
    end
  endtask

  task automatic test_eoi();
    drive(8'h20, 1'b0, 3'd0, 1'b1, 3'd5);
    cyc();
    total++;
    if (bus.eoi_out !== 8'h20 || bus.in_service !== 8'h00) begin
      bad++; $display("FAIL eoi_hit got=%h/%h exp=20/00", bus.eoi_out, bus.in_service);
    end
    total++;
    if (bus.eoi_err !== 1'b0) begin
      bad++; $display("FAIL eoi_no_err got=%b exp=0", bus.eoi_err);
    end
    cyc();
    total++;
    if (bus.eoi_err !== 1'b1 || bus.eoi_out !== 8'h00) begin
      bad++; $display("FAIL eoi_err got=%b/%h exp=1/00", bus.eoi_err, bus.eoi_out);
    end
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.eoi_err !== 1'b0) begin
      bad++; $display("FAIL eoi_err_end got=%b exp=0", bus.eoi_err);
    end
  endtask

  task automatic test_ack_err();
    drive(8'h01, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    drive(8'h01, 1'b1, 3'd3, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.ack_err !== 1'b1) begin
      bad++; $display("FAIL ackerr_pulse got=%b exp=1", bus.ack_err);
    end
    total++;
    if (bus.pending !== 8'h01 || bus.in_service !== 8'h00 || bus.irq_ack_out !== 8'h00) begin
      bad++; $display("FAIL ackerr_state got=%h/%h/%h exp=01/00/00",
        bus.pending, bus.in_service, bus.irq_ack_out);
    end
    drive(8'h01, 1'b1, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.ack_err !== 1'b0 || bus.in_service !== 8'h01 || bus.pending !== 8'h00) begin
      bad++; $display("FAIL ackerr_recover got=%b/%h/%h exp=0/01/00",
        bus.ack_err, bus.in_service, bus.pending);
    end
    drive(8'h00, 1'b0, 3'd0, 1'b1, 3'd0);
    cyc();
    total++;
    if (bus.in_service !== 8'h00 || bus.eoi_out !== 8'h01) begin
      bad++; $display("FAIL ackerr_cleanup got=%h/%h exp=00/01", bus.in_service, bus.eoi_out);
    end
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
  endtask

  task automatic test_level_reedge();
    int  sets;
    logic prev_p;
    logic [7:0] exp_p;
    sets   = 0;
    prev_p = bus.pending[2];
    // Hold high 10 cycles; ack line 2 on the second cycle to clear it.
    for (int i = 0; i < 10; i++) begin
      drive(8'h04, (i == 1), 3'd2, 1'b0, 3'd0);
      cyc();
      exp_p = (i == 0) ? 8'h04 : 8'h00;
      total++;
      if (bus.pending !== exp_p) begin
        bad++; $display("FAIL level_hold_%0d got=%h exp=%h", i, bus.pending, exp_p);
      end
      if (bus.pending[2] && !prev_p) sets++;
      prev_p = bus.pending[2];
    end
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    if (bus.pending[2] && !prev_p) sets++;
    prev_p = bus.pending[2];
    drive(8'h04, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.pending !== 8'h04) begin
      bad++; $display("FAIL reedge_pending got=%h exp=04", bus.pending);
    end
    if (bus.pending[2] && !prev_p) sets++;
    total++;
    if (sets !== 2) begin
      bad++; $display("FAIL level_set_count got=%0d exp=2", sets);
    end
    // Re-entrant ack while line 2 is still in service.
    drive(8'h04, 1'b1, 3'd2, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.irq_ack_out !== 8'h04 || bus.in_service !== 8'h04 || bus.ack_err !== 1'b0) begin
      bad++; $display("FAIL reentrant_ack got=%h/%h/%b exp=04/04/0",
        bus.irq_ack_out, bus.in_service, bus.ack_err);
    end
    drive(8'h00, 1'b0, 3'd0, 1'b1, 3'd2);
    cyc();
    total++;
    if (bus.in_service !== 8'h00 || bus.pending !== 8'h00) begin
      bad++; $display("FAIL reentrant_eoi got=%h/%h exp=00/00", bus.in_service, bus.pending);
    end
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
  endtask

  task automatic test_collision();
    drive(8'h10, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    drive(8'h10, 1'b1, 3'd4, 1'b0, 3'd0);
    cyc();
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    drive(8'h10, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.pending !== 8'h10 || bus.in_service !== 8'h10) begin
      bad++; $display("FAIL coll_setup got=%h/%h exp=10/10", bus.pending, bus.in_service);
    end
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    // Ack 4, EOI 4 and a new rise on line 4 in the same cycle.
    drive(8'h10, 1'b1, 3'd4, 1'b1, 3'd4);
    cyc();
    total++;
    if (bus.irq_ack_out !== 8'h10 || bus.eoi_out !== 8'h10) begin
      bad++; $display("FAIL coll_pulses got=%h/%h exp=10/10", bus.irq_ack_out, bus.eoi_out);
    end
    total++;
    if (bus.pending !== 8'h10 || bus.in_service !== 8'h10) begin
      bad++; $display("FAIL coll_state got=%h/%h exp=10/10", bus.pending, bus.in_service);
    end
    total++;
    if (bus.ack_err !== 1'b0 || bus.eoi_err !== 1'b0) begin
      bad++; $display("FAIL coll_errs got=%b%b exp=00", bus.ack_err, bus.eoi_err);
    end
  endtask

  task automatic test_back_to_back_and_reset();
    logic [7:0] exp_a;
    reset = 1'b1;
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    reset = 1'b0;
    drive(8'h0F, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.pending !== 8'h0F) begin
      bad++; $display("FAIL b2b_pending got=%h exp=0F", bus.pending);
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'h0F, 1'b1, 3'(i), 1'b0, 3'd0);
      cyc();
      exp_a = 8'h01 << i;
      total++;
      if (bus.irq_ack_out !== exp_a) begin
        bad++; $display("FAIL b2b_ack_%0d got=%h exp=%h", i, bus.irq_ack_out, exp_a);
      end
    end
    total++;
    if (bus.pending !== 8'h00 || bus.in_service !== 8'h0F) begin
      bad++; $display("FAIL b2b_state got=%h/%h exp=00/0F", bus.pending, bus.in_service);
    end
    drive(8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    drive(8'hFF, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.pending !== 8'hFF || bus.in_service !== 8'h0F) begin
      bad++; $display("FAIL midrst_setup got=%h/%h exp=FF/0F", bus.pending, bus.in_service);
    end
    // Reset with lines held high, and a command that must not pulse.
    reset = 1'b1;
    drive(8'hFF, 1'b1, 3'd7, 1'b1, 3'd0);
    cyc();
    total++;
    if ({bus.pending, bus.in_service, bus.irq_ack_out, bus.eoi_out} !== 32'h0) begin
      bad++; $display("FAIL midrst_vectors got=%h exp=%h",
        {bus.pending, bus.in_service, bus.irq_ack_out, bus.eoi_out}, 32'h0);
    end
    total++;
    if ({bus.irq_req, bus.ack_err, bus.eoi_err} !== 3'b000) begin
      bad++; $display("FAIL midrst_flags got=%b exp=000", {bus.irq_req, bus.ack_err, bus.eoi_err});
    end
    reset = 1'b0;
    drive(8'hFF, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc();
    total++;
    if (bus.pending !== 8'hFF || bus.in_service !== 8'h00 || bus.irq_req !== 1'b1) begin
      bad++; $display("FAIL postrst_edges got=%h/%h/%b exp=FF/00/1",
        bus.pending, bus.in_service, bus.irq_req);
    end
  endtask

  // Sequence and final report
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_ack();
    test_eoi();
    test_ack_err();
    test_level_reedge();
    test_collision();
    test_back_to_back_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ack_decoder.md
Name: irq_ack_decoder

Overview:
- Interrupt pending/in-service tracker for the CPU interrupt path.
- Latches rising edges on peripheral request lines into a pending vector. The pending vector feeds the priority encoder, which turns it into an index for the CPU.
- Goes the opposite way to that encoder: decodes the CPU's acknowledge and end-of-interrupt (EOI) indices back into one-hot masks. Those masks clear pending bits, set and clear in-service bits, and drive one-cycle one-hot pulses back to the peripherals.

Parameters:
- N, 8, number of interrupt lines. Legal values: 4, 8, 16.
- W, 3, index width. Must equal log2(N).

Ports:
- clk  input  1  system clock. Rising-edge active.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  N  raw peripheral request lines, edge-sensitive.
- ack_valid  input  1  CPU acknowledges interrupt ack_index this cycle.
- ack_index  input  W  index being acknowledged, taken from the encoder output.
- eoi_valid  input  1  CPU signals end of interrupt eoi_index this cycle.
- eoi_index  input  W  index being retired.
- pending  output  N  registered pending vector. Feeds the priority encoder.
- in_service  output  N  registered in-service vector.
- irq_req  output  1  combinational OR of pending.
- irq_ack_out  output  N  registered one-hot acknowledge pulse, one cycle wide.
- eoi_out  output  N  registered one-hot EOI pulse, one cycle wide.
- ack_err  output  1  registered one-cycle pulse: ack of a non-pending index.
- eoi_err  output  1  registered one-cycle pulse: EOI of a non-in-service index.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - reset is synchronous and active-high.
  - While reset is sampled high, every register goes to 0: irq_prev, pending, in_service, irq_ack_out, eoi_out, ack_err, eoi_err.
  - irq_req is therefore 0 after reset.
  - Reset mid-operation discards all pending and in-service state. No pulses are emitted on the reset cycle.
- Edge detection:
  - irq_prev <= irq_in every cycle.
  - rise = irq_in & ~irq_prev.
  - A line already high when reset deasserts counts as a rising edge on the first cycle after reset.
  - A line held high produces exactly one rise.
- Decoders:
  - ack_dec = one-hot(ack_index), gated by ack_valid. All zero if ack_valid = 0.
  - eoi_dec = one-hot(eoi_index), gated by eoi_valid. All zero if eoi_valid = 0.
- Acknowledge:
  - ack_hit = ack_dec & pending, evaluated on current state.
  - If ack_hit is nonzero: the bit is cleared from pending, set in in_service, and irq_ack_out = ack_hit for the next cycle.
  - If ack_valid = 1 and ack_hit = 0: ack_err pulses for the next cycle, and no state changes.
- End of interrupt:
  - eoi_hit = eoi_dec & in_service, evaluated on current state.
  - If eoi_hit is nonzero: the bit is cleared from in_service, and eoi_out = eoi_hit for the next cycle.
  - If eoi_valid = 1 and eoi_hit = 0: eoi_err pulses for the next cycle.
- Next-state equations:
  - pending_next = (pending & ~ack_hit) | rise. A new edge on the same line in the ack cycle re-arms pending.
  - in_service_next = (in_service & ~eoi_hit) | ack_hit.
- Simultaneous ack and EOI on the same index:
  - The EOI sees the old in_service and the ack sees the old pending.
  - That bit ends with in_service = 1. Both pulses fire.
- Latency:
  - irq_in rising at edge n: pending is set after edge n, and irq_req is high in the same cycle.
  - ack_valid sampled at edge n: irq_ack_out, in_service and pending all update after edge n.
  - All pulses are exactly one cycle wide. Back-to-back acks in consecutive cycles are allowed.
- Re-entrant line:
  - A line that is in service may become pending again on a new edge.
  - Its second ack is allowed while it is still in service. in_service stays 1.
- Indices:
  - Always in range, since N = 2^W. No out-of-range handling is required.

Test Plan:
1. Reset then basic ack (N=8):
   - Stimulus: reset for 2 cycles. irq_in = 8'h20 one cycle after release.
   - Required: pending = 8'h20 and irq_req = 1. Then ack_valid = 1, ack_index = 5 gives irq_ack_out = 8'h20 for one cycle, pending = 0, in_service = 8'h20.
2. EOI and EOI error:
   - Stimulus: from case 1, eoi_valid = 1, eoi_index = 5. Next cycle, eoi_index = 5 again.
   - Required: first gives eoi_out = 8'h20 and in_service = 0. Second gives eoi_err = 1 for one cycle and eoi_out = 0.
3. Ack of a non-pending index:
   - Stimulus: pending = 8'h01, ack_index = 3.
   - Required: ack_err pulses. pending stays 8'h01, in_service stays 0, irq_ack_out = 0.
4. Level held and re-edge:
   - Stimulus: irq_in[2] held high for 10 cycles. Then low for 1 cycle, then high again.
   - Required: exactly 2 set events on pending[2], each visible the cycle after its rise.
5. Same-cycle collisions:
   - Stimulus: pending[4] = 1, in_service[4] = 1. In one cycle: ack 4, EOI 4, and a new rise on irq_in[4].
   - Required: irq_ack_out = 8'h10, eoi_out = 8'h10, pending[4] = 1, in_service[4] = 1.
6. Reset mid-operation:
   - Stimulus: pending = 8'hFF, in_service = 8'h0F, reset high for 1 cycle while irq_in = 8'hFF.
   - Required: all outputs 0 after reset. pending = 8'hFF one cycle after release, because high lines count as edges.
